// File: rtl/tl_traffic_gen.sv
// TileLink-UL master traffic generator: LFSR-patterned Put/Get beats, up to
// MAX_OUTST in flight, each D response checked against a per-source slot table.
module tl_traffic_gen #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int SOURCE_W  = 4,
   parameter int MAX_OUTST = 4,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            mode,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      num_txn,
   input  logic [31:0]           seed,
   output logic                  a_valid,
   input  logic                  a_ready,
   output logic [2:0]            a_opcode,
   output logic [2:0]            a_size,
   output logic [SOURCE_W-1:0]   a_source,
   output logic [ADDR_W-1:0]     a_address,
   output logic [DATA_W/8-1:0]   a_mask,
   output logic [DATA_W-1:0]     a_data,
   input  logic                  d_valid,
   output logic                  d_ready,
   input  logic [2:0]            d_opcode,
   input  logic [SOURCE_W-1:0]   d_source,
   input  logic                  d_denied,
   input  logic [DATA_W-1:0]     d_data,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count
);
   localparam int DATA_BYTES = DATA_W / 8;
   localparam int SIZE_LOG   = $clog2(DATA_BYTES);
   localparam int OUT_W      = $clog2(MAX_OUTST + 1);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_DRAIN, S_RD, S_RD_DRAIN, S_DONE} state_t;
   state_t state, state_nxt, after_wr;

   logic [1:0]            mode_q;
   logic [ADDR_W-1:0]     base_q, addr_q;
   logic [CNT_W-1:0]      num_q, issued;
   logic [31:0]           seed_q, lfsr, lfsr_step, seed_in_nz, seed_load;
   logic                  abort_q, held;
   logic [SOURCE_W-1:0]   held_slot, free_sel, cur_slot;
   logic [OUT_W-1:0]      outstanding;
   logic [15:0]           err_q;

   logic [MAX_OUTST-1:0]  slot_busy, slot_get;
   logic [DATA_W-1:0]     slot_data [MAX_OUTST];
   logic [DATA_BYTES-1:0] slot_mask [MAX_OUTST];

   logic                  issue_st, is_rd, free_any, a_fire, d_fire, finished, phase_load;
   logic                  hit_busy, hit_get, resp_err;
   logic [DATA_BYTES-1:0] mask_raw, cur_mask, hit_mask;
   logic [DATA_W-1:0]     cur_data, hit_data, byte_en;

   // Valid/ready: a beat or response transfers on a rising edge where both are high;
   // once a_valid rises, every A field stays frozen until a_ready is seen.
   assign issue_st   = (state == S_WR) || (state == S_RD);
   assign is_rd      = (state == S_RD);
   assign busy       = issue_st || (state == S_WR_DRAIN) || (state == S_RD_DRAIN);
   assign d_ready    = busy;
   assign done       = (state == S_DONE);
   assign pass       = done && (err_q == 16'd0) && !abort_q;
   assign err_count  = err_q;

   assign a_valid    = issue_st && (held || ((issued < num_q) && free_any && !abort_q));
   assign cur_slot   = held ? held_slot : free_sel;
   assign a_fire     = a_valid && a_ready;
   assign d_fire     = d_valid && d_ready;
   assign finished   = (issued >= num_q) || abort_q;

   assign lfsr_step  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
   assign mask_raw   = DATA_BYTES'(lfsr);
   assign cur_mask   = (mode_q == 2'd3 && mask_raw != '0) ? mask_raw : '1;
   assign cur_data   = {(DATA_W/32){lfsr}};

   assign a_opcode   = !a_valid ? 3'd0 : is_rd ? 3'd4 : (mode_q == 2'd3) ? 3'd1 : 3'd0;
   assign a_size     = a_valid ? 3'(SIZE_LOG) : 3'd0;
   assign a_source   = a_valid ? cur_slot : '0;
   assign a_address  = a_valid ? addr_q : '0;
   assign a_mask     = a_valid ? cur_mask : '0;
   assign a_data     = (a_valid && !is_rd) ? cur_data : '0;

   assign seed_in_nz = (seed == 32'd0) ? 32'd1 : seed;
   assign seed_load  = (state == S_IDLE) ? seed_in_nz : seed_q;
   assign after_wr   = (abort_q || mode_q == 2'd0) ? S_DONE : S_RD;
   assign phase_load = ((state == S_IDLE) && start) || ((state_nxt == S_RD) && (state != S_RD));

   always_comb begin
      free_any = 1'b0;
      free_sel = '0;
      for (int s = MAX_OUTST - 1; s >= 0; s--) begin
         if (!slot_busy[s]) begin
            free_any = 1'b1;
            free_sel = SOURCE_W'(s);
         end
      end
   end

   // An out-of-range d_source matches no slot and so reads as "not busy".
   always_comb begin
      hit_busy = 1'b0;
      hit_get  = 1'b0;
      hit_data = '0;
      hit_mask = '0;
      byte_en  = '0;
      for (int s = 0; s < MAX_OUTST; s++) begin
         if (d_source == SOURCE_W'(s)) begin
            hit_busy = slot_busy[s];
            hit_get  = slot_get[s];
            hit_data = slot_data[s];
            hit_mask = slot_mask[s];
         end
      end
      for (int b = 0; b < DATA_BYTES; b++) byte_en[b*8 +: 8] = {8{hit_mask[b]}};
      resp_err = d_denied || !hit_busy || (d_opcode != (hit_get ? 3'd1 : 3'd0)) ||
                 (hit_get && (((d_data ^ hit_data) & byte_en) != '0));
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:     if (start) state_nxt = (mode == 2'd1) ? S_RD : S_WR;
         S_WR:       if (!a_valid && finished) state_nxt = (outstanding != '0) ? S_WR_DRAIN : after_wr;
         S_WR_DRAIN: if (outstanding == '0) state_nxt = after_wr;
         S_RD:       if (!a_valid && finished) state_nxt = (outstanding != '0) ? S_RD_DRAIN : S_DONE;
         S_RD_DRAIN: if (outstanding == '0) state_nxt = S_DONE;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         mode_q      <= 2'd0;
         base_q      <= '0;
         num_q       <= '0;
         seed_q      <= 32'd1;
         lfsr        <= 32'd1;
         addr_q      <= '0;
         issued      <= '0;
         abort_q     <= 1'b0;
         held        <= 1'b0;
         held_slot   <= '0;
         outstanding <= '0;
         err_q       <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) && start) begin
            mode_q  <= mode;
            base_q  <= base_addr;
            num_q   <= num_txn;
            seed_q  <= seed_in_nz;
            err_q   <= '0;
            abort_q <= 1'b0;
         end
         if (abort && busy) abort_q <= 1'b1;
         held <= a_valid && !a_ready;
         if (a_valid && !a_ready) held_slot <= cur_slot;
         if (phase_load) begin
            lfsr   <= seed_load;
            addr_q <= (state == S_IDLE) ? base_addr : base_q;
            issued <= '0;
         end else if (a_fire) begin
            lfsr   <= lfsr_step;
            addr_q <= addr_q + ADDR_W'(DATA_BYTES);
            issued <= issued + CNT_W'(1);
         end
         if (a_fire && !(d_fire && hit_busy))      outstanding <= outstanding + OUT_W'(1);
         else if (!a_fire && d_fire && hit_busy)   outstanding <= outstanding - OUT_W'(1);
         if (d_fire && resp_err && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      end
   end

   // The accepted slot is always free and a freed slot is always busy, so they never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_busy <= '0;
         slot_get  <= '0;
         for (int s = 0; s < MAX_OUTST; s++) begin
            slot_data[s] <= '0;
            slot_mask[s] <= '0;
         end
      end else begin
         for (int s = 0; s < MAX_OUTST; s++) begin
            if (a_fire && cur_slot == SOURCE_W'(s)) begin
               slot_busy[s] <= 1'b1;
               slot_get[s]  <= is_rd;
               slot_data[s] <= cur_data;
               slot_mask[s] <= cur_mask;
            end else if (d_fire && hit_busy && d_source == SOURCE_W'(s)) begin
               slot_busy[s] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_tl_traffic_gen.sv
// Directed bench for tl_traffic_gen: a memory responder on the A/D channels and one task per scenario.
module tb_tl_traffic_gen;
   logic        clk, rst_n, start, abort;
   logic [1:0]  mode;
   logic [31:0] base_addr, seed;
   logic [15:0] num_txn;
   logic        a_valid, a_ready, d_valid, d_ready, d_denied;
   logic [2:0]  a_opcode, a_size, d_opcode;
   logic [3:0]  a_source, d_source;
   logic [31:0] a_address;
   logic [7:0]  a_mask;
   logic [63:0] a_data, d_data;
   logic        busy, done, pass;
   logic [15:0] err_count;

   tl_traffic_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .base_addr(base_addr), .num_txn(num_txn), .seed(seed),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
      .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
      .d_denied(d_denied), .d_data(d_data),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // responder and monitor state
   logic [63:0] mem [logic [31:0]];
   logic [31:0] lg_addr[$];
   logic [2:0]  lg_op[$];
   logic [63:0] lg_data[$];
   logic [7:0]  lg_mask[$];
   logic [3:0]  lg_src[$];
   int          lg_cyc[$];
   logic [3:0]  pq_src[$];
   logic [2:0]  pq_op[$];
   logic [63:0] pq_data[$];
   logic [63:0] exp_q[$];
   logic [15:0] inflight;
   logic [31:0] flip_addr;
   int cyc, done_seen, err_seen, n_puts, n_gets, n_stall, n_ooo;
   int stall_viol, src_viol, max_infl, deny_cnt;
   logic pass_seen, rev_mode, rdy_mode, abort_arm, abort_now, was_stall;
   logic [113:0] held_f, cur_f;

   function automatic logic [31:0] lfsr_nx(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   initial begin
      int k;
      logic [63:0] rd;
      a_ready = 1'b0; d_valid = 1'b0; d_denied = 1'b0; d_opcode = 3'd0;
      d_source = 4'd0; d_data = 64'd0; abort = 1'b0;
      cyc = 0; was_stall = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done) begin
            done_seen++; pass_seen = pass; err_seen = int'(err_count);
         end
         abort = 1'b0;
         if (abort_arm && n_puts >= 3) begin abort = 1'b1; abort_arm = 1'b0; end
         if (abort_now) begin abort = 1'b1; abort_now = 1'b0; end
         // D channel: responses only for beats accepted at earlier edges
         d_valid = 1'b0; d_denied = 1'b0; d_opcode = 3'd0; d_source = 4'd0; d_data = 64'd0;
         if (d_ready && pq_src.size() > 0 && (!rev_mode || !a_valid || pq_src.size() >= 4)) begin
            k = rev_mode ? pq_src.size() - 1 : 0;
            if (k != 0) n_ooo++;
            d_valid = 1'b1; d_source = pq_src[k]; d_opcode = pq_op[k]; d_data = pq_data[k];
            if (deny_cnt > 0) begin d_denied = 1'b1; deny_cnt--; end
            inflight[pq_src[k]] = 1'b0;
            pq_src.delete(k); pq_op.delete(k); pq_data.delete(k);
         end
         // A channel
         a_ready = (rdy_mode == 1'b0) ? 1'b1 : ((cyc % 3) == 0);
         if (a_valid) begin
            cur_f = {a_address, a_opcode, a_size, a_source, a_mask, a_data};
            if (was_stall && cur_f !== held_f) stall_viol++;
            if (a_ready) begin
               was_stall = 1'b0;
               if (a_source > 4'd3 || inflight[a_source]) src_viol++;
               inflight[a_source] = 1'b1;
               if ($countones(inflight) > max_infl) max_infl = $countones(inflight);
               lg_addr.push_back(a_address); lg_op.push_back(a_opcode); lg_data.push_back(a_data);
               lg_mask.push_back(a_mask); lg_src.push_back(a_source); lg_cyc.push_back(cyc);
               rd = mem.exists(a_address) ? mem[a_address] : 64'd0;
               if (a_opcode == 3'd4) begin
                  if (a_address == flip_addr) rd[0] = ~rd[0];
                  pq_op.push_back(3'd1); pq_data.push_back(rd); n_gets++;
               end else begin
                  for (int b = 0; b < 8; b++) if (a_mask[b]) rd[b*8 +: 8] = a_data[b*8 +: 8];
                  mem[a_address] = rd;
                  pq_op.push_back(3'd0); pq_data.push_back(64'd0); n_puts++;
               end
               pq_src.push_back(a_source);
            end else begin
               was_stall = 1'b1; held_f = cur_f; n_stall++;
            end
         end else begin
            if (was_stall) stall_viol++;
            was_stall = 1'b0;
         end
      end
   end

   // driver tasks
   task automatic clear_bench();
      lg_addr.delete(); lg_op.delete(); lg_data.delete(); lg_mask.delete(); lg_src.delete();
      lg_cyc.delete(); pq_src.delete(); pq_op.delete(); pq_data.delete(); mem.delete();
      inflight = '0; flip_addr = 32'hFFFF_FFFF; done_seen = 0; err_seen = 0; pass_seen = 1'b0;
      n_puts = 0; n_gets = 0; n_stall = 0; n_ooo = 0; stall_viol = 0; src_viol = 0;
      max_infl = 0; deny_cnt = 0; rev_mode = 1'b0; rdy_mode = 1'b0;
      abort_arm = 1'b0; abort_now = 1'b0; was_stall = 1'b0;
   endtask

   task automatic kick(input logic [1:0] m, input logic [31:0] b, input logic [15:0] n,
                       input logic [31:0] s);
      @(negedge clk);
      mode = m; base_addr = b; num_txn = n; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input logic [1:0] m, input logic [31:0] b, input logic [15:0] n,
                      input logic [31:0] s, output logic ok);
      kick(m, b, n, s);
      for (int t = 0; t < 3000 && done_seen == 0; t++) @(negedge clk);
      ok = (done_seen > 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; mode = 2'd0; base_addr = '0; num_txn = '0; seed = '0;
      clear_bench();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (a_valid !== 1'b0)    begin n_err++; $display("FAIL rst_a_valid: got %b want 0", a_valid); end
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (pass !== 1'b0)       begin n_err++; $display("FAIL rst_pass: got %b want 0", pass); end
      n_cmp++; if (d_ready !== 1'b0)    begin n_err++; $display("FAIL rst_d_ready: got %b want 0", d_ready); end
      n_cmp++; if (err_count !== 16'd0) begin n_err++; $display("FAIL rst_err: got %0d want 0", err_count); end
   endtask

   task automatic test_write_read();
      logic ok;
      logic [31:0] v;
      clear_bench();
      run(2'd2, 32'h1000, 16'd8, 32'hACE1, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_rd_timeout: got no done want done"); end
      n_cmp++; if (done_seen !== 1) begin n_err++; $display("FAIL wr_rd_done_pulses: got %0d want 1", done_seen); end
      n_cmp++; if (pass_seen !== 1'b1) begin n_err++; $display("FAIL wr_rd_pass: got %b want 1", pass_seen); end
      n_cmp++; if (err_seen !== 0) begin n_err++; $display("FAIL wr_rd_err: got %0d want 0", err_seen); end
      n_cmp++; if (lg_addr.size() !== 16) begin n_err++; $display("FAIL wr_rd_beats: got %0d want 16", lg_addr.size()); end
      if (lg_addr.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (lg_addr[i] !== 32'h1000 + 32'(8 * (i % 8)) || lg_op[i] !== ((i < 8) ? 3'd0 : 3'd4) ||
                lg_mask[i] !== 8'hFF) begin
               n_err++;
               $display("FAIL wr_rd_beat[%0d]: got addr %h op %0d mask %h want addr %h op %0d mask ff",
                        i, lg_addr[i], lg_op[i], lg_mask[i], 32'h1000 + 32'(8 * (i % 8)), (i < 8) ? 0 : 4);
            end
         end
         exp_q.delete();
         exp_q.push_back(64'h0000ACE1_0000ACE1);
         exp_q.push_back(64'h80205673_80205673);
         exp_q.push_back(64'hC0302B3A_C0302B3A);
         v = 32'hC0302B3A;
         for (int i = 3; i < 8; i++) begin v = lfsr_nx(v); exp_q.push_back({v, v}); end
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (lg_data[i] !== exp_q[i]) begin
               n_err++; $display("FAIL wr_data[%0d]: got %h want %h", i, lg_data[i], exp_q[i]);
            end
         end
         n_cmp++; if (mem[32'h1038] !== exp_q[7]) begin n_err++; $display("FAIL mem_1038: got %h want %h", mem[32'h1038], exp_q[7]); end
         // back-to-back issue with a_ready held high, lowest free slot first
         n_cmp++; if (lg_cyc[1] - lg_cyc[0] !== 1 || lg_cyc[2] - lg_cyc[1] !== 1) begin
            n_err++; $display("FAIL back_to_back: got gaps %0d %0d want 1 1", lg_cyc[1] - lg_cyc[0], lg_cyc[2] - lg_cyc[1]);
         end
         n_cmp++; if (lg_src[0] !== 4'd0 || lg_src[1] !== 4'd1) begin
            n_err++; $display("FAIL first_sources: got %0d %0d want 0 1", lg_src[0], lg_src[1]);
         end
         n_cmp++; if (lg_size_ok() !== 1'b1) begin n_err++; $display("FAIL a_size: got mismatch want 3"); end
      end
   endtask

   logic size_ok_latch;
   function automatic logic lg_size_ok();
      return size_ok_latch;
   endfunction
   initial begin
      size_ok_latch = 1'b1;
      forever begin
         @(negedge clk);
         if (a_valid && a_size !== 3'd3) size_ok_latch = 1'b0;
      end
   end

   task automatic test_reverse();
      logic ok;
      clear_bench();
      rev_mode = 1'b1;
      run(2'd2, 32'h1000, 16'd8, 32'hACE1, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rev_timeout: got no done want done"); end
      n_cmp++; if (pass_seen !== 1'b1 || err_seen !== 0) begin n_err++; $display("FAIL rev_pass: got pass %b err %0d want 1 0", pass_seen, err_seen); end
      n_cmp++; if (lg_addr.size() !== 16) begin n_err++; $display("FAIL rev_beats: got %0d want 16", lg_addr.size()); end
      n_cmp++; if (src_viol !== 0 || max_infl > 4) begin n_err++; $display("FAIL rev_sources: got viol %0d max %0d want 0 <=4", src_viol, max_infl); end
      n_cmp++; if (n_ooo == 0) begin n_err++; $display("FAIL rev_out_of_order: got %0d reordered want >0", n_ooo); end
   endtask

   task automatic test_bit_flip();
      logic ok;
      clear_bench();
      flip_addr = 32'h1018;
      run(2'd2, 32'h1000, 16'd8, 32'hACE1, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL flip_timeout: got no done want done"); end
      n_cmp++; if (err_seen !== 1) begin n_err++; $display("FAIL flip_err: got %0d want 1", err_seen); end
      n_cmp++; if (pass_seen !== 1'b0) begin n_err++; $display("FAIL flip_pass: got %b want 0", pass_seen); end
   endtask

   task automatic test_partial();
      logic ok;
      logic [7:0] em [4];
      em[0] = 8'h01; em[1] = 8'h03; em[2] = 8'h02; em[3] = 8'h01;
      clear_bench();
      for (int i = 0; i < 4; i++) mem[32'h2000 + 32'(8 * i)] = 64'hEEEE_EEEE_EEEE_EEEE;
      run(2'd3, 32'h2000, 16'd4, 32'd1, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL part_timeout: got no done want done"); end
      n_cmp++; if (pass_seen !== 1'b1 || err_seen !== 0) begin n_err++; $display("FAIL part_pass: got pass %b err %0d want 1 0", pass_seen, err_seen); end
      n_cmp++; if (lg_op.size() !== 8) begin n_err++; $display("FAIL part_beats: got %0d want 8", lg_op.size()); end
      if (lg_op.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (lg_op[i] !== ((i < 4) ? 3'd1 : 3'd4) || lg_mask[i] !== em[i % 4]) begin
               n_err++; $display("FAIL part_beat[%0d]: got op %0d mask %h want op %0d mask %h",
                                 i, lg_op[i], lg_mask[i], (i < 4) ? 1 : 4, em[i % 4]);
            end
         end
      end
      n_cmp++; if (mem[32'h2000] !== 64'hEEEEEEEE_EEEEEE01) begin n_err++; $display("FAIL part_mem0: got %h want eeeeeeeeeeeeee01", mem[32'h2000]); end
      n_cmp++; if (mem[32'h2008] !== 64'hEEEEEEEE_EEEE0003) begin n_err++; $display("FAIL part_mem1: got %h want eeeeeeeeeeee0003", mem[32'h2008]); end
   endtask

   task automatic test_stall();
      logic ok;
      clear_bench();
      rdy_mode = 1'b1;
      run(2'd2, 32'h1000, 16'd8, 32'h5A5A_0001, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout: got no done want done"); end
      n_cmp++; if (lg_addr.size() !== 16) begin n_err++; $display("FAIL stall_beats: got %0d want 16", lg_addr.size()); end
      n_cmp++; if (n_stall == 0 || stall_viol !== 0) begin n_err++; $display("FAIL stall_hold: got stalls %0d violations %0d want >0 0", n_stall, stall_viol); end
      n_cmp++; if (pass_seen !== 1'b1) begin n_err++; $display("FAIL stall_pass: got %b want 1", pass_seen); end
   endtask

   task automatic test_abort();
      logic ok;
      clear_bench();
      abort_arm = 1'b1;
      deny_cnt = 1;
      run(2'd2, 32'h3000, 16'd10, 32'h1234, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_timeout: got no done want done"); end
      n_cmp++; if (n_puts > 4 || n_puts < 3) begin n_err++; $display("FAIL abort_puts: got %0d want 3..4", n_puts); end
      n_cmp++; if (n_gets !== 0) begin n_err++; $display("FAIL abort_gets: got %0d want 0", n_gets); end
      n_cmp++; if (pass_seen !== 1'b0) begin n_err++; $display("FAIL abort_pass: got %b want 0", pass_seen); end
      n_cmp++; if (err_seen !== 1) begin n_err++; $display("FAIL denied_err: got %0d want 1", err_seen); end
   endtask

   task automatic test_zero();
      int k;
      clear_bench();
      abort_now = 1'b1;
      repeat (3) @(negedge clk);
      kick(2'd2, 32'h4000, 16'd0, 32'h77);
      k = 1;
      while (k < 10 && !done) begin @(negedge clk); k++; end
      n_cmp++; if (k > 3) begin n_err++; $display("FAIL zero_latency: got %0d cycles want <=3", k); end
      n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL zero_pass: got %b want 1", pass); end
      repeat (3) @(negedge clk);
      n_cmp++; if (lg_addr.size() !== 0) begin n_err++; $display("FAIL zero_beats: got %0d want 0", lg_addr.size()); end
   endtask

   task automatic test_reset_mid();
      clear_bench();
      kick(2'd2, 32'h1000, 16'd8, 32'hACE1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #2;
      n_cmp++; if (busy !== 1'b0 || a_valid !== 1'b0 || d_ready !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_outs: got busy %b a_valid %b d_ready %b want 0 0 0", busy, a_valid, d_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      clear_bench();
      repeat (10) @(negedge clk);
      n_cmp++; if (done_seen !== 0 || busy !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_idle: got done %0d busy %b want 0 0", done_seen, busy);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_reverse();
      test_bit_flip();
      test_partial();
      test_stall();
      test_abort();
      test_zero();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
